// File: rtl/if1_fetch_ctrl_if.sv
// Bundles the I-cache request/response channel and the IB write port
// of the IF1 fetch controller.
interface if1_fetch_ctrl_if #(
  parameter int IB_WIDTH_LOG2  = 4,
  parameter int IB_DATA_BUS_WD = 65
);
  logic                          icache_req_valid;
  logic                          icache_req_ready;
  logic [31:0]                   icache_req_addr;
  logic                          icache_rsp_valid;
  logic [127:0]                  icache_rsp_data;
  logic [4*IB_DATA_BUS_WD-1:0]   if1_to_ib;
  logic [2:0]                    push_num;
  logic [IB_WIDTH_LOG2:0]        if_bf_sz;

  modport master (
    output icache_req_valid, icache_req_addr, if1_to_ib, push_num,
    input  icache_req_ready, icache_rsp_valid, icache_rsp_data, if_bf_sz
  );

  modport slave (
    input  icache_req_valid, icache_req_addr, if1_to_ib, push_num,
    output icache_rsp_valid, icache_rsp_data, icache_req_ready, if_bf_sz
  );
endinterface

// File: rtl/if1_fetch_ctrl.sv
// IF1 fetch controller: one outstanding aligned 16-byte I-cache fetch at a time,
// unpacks the returned line into up to four IB entries when the IB has room.
module if1_fetch_ctrl #(
  parameter int          IB_WIDTH       = 16,
  parameter int          IB_WIDTH_LOG2  = 4,
  parameter int          IB_DATA_BUS_WD = 65,
  parameter logic [31:0] RESET_PC       = 32'h1c00_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [31:0]          redirect_pc,
  if1_fetch_ctrl_if.master     bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, DROP} state_t;

  localparam logic [IB_WIDTH_LOG2:0] IB_DEPTH = (IB_WIDTH_LOG2 + 1)'(IB_WIDTH);

  state_t                        state_q, state_d;
  logic [31:0]                   pc_q, pc_d;
  logic [127:0]                  line_q, line_d;
  logic [31:0]                   line_base;
  logic [2:0]                    n_avail;
  logic [IB_WIDTH_LOG2:0]        space;
  logic                          fits;
  logic                          req_hs;
  logic [2:0]                    push_n;
  logic [4*IB_DATA_BUS_WD-1:0]   ib_bus;

  assign line_base = pc_q & 32'hffff_fff0;
  assign n_avail   = 3'd4 - {1'b0, pc_q[3:2]};
  // Wraps to a large value if occupancy were ever illegal; the assertion below guards that.
  assign space     = IB_DEPTH - bus.if_bf_sz;
  assign fits      = (IB_WIDTH_LOG2 + 1)'(n_avail) <= space;
  assign req_hs    = (state_q == REQ) && bus.icache_req_ready;

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    line_d  = line_q;
    push_n  = '0;
    if (flush) begin
      pc_d = redirect_pc & 32'hffff_fffc;
      case (state_q)
        IDLE, PUSH: begin
          state_d = REQ;
          line_d  = '0;
        end
        REQ:     state_d = req_hs ? DROP : REQ;
        WAIT:    state_d = bus.icache_rsp_valid ? REQ : DROP;
        DROP:    state_d = bus.icache_rsp_valid ? REQ : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  if (req_hs) state_d = WAIT;
        WAIT: if (bus.icache_rsp_valid) begin
          line_d  = bus.icache_rsp_data;
          state_d = PUSH;
        end
        PUSH: if (fits) begin
          push_n  = n_avail;
          pc_d    = line_base + 32'd16;
          state_d = REQ;
        end
        DROP:    if (bus.icache_rsp_valid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Entry j takes word pc[3:2]+j of the line; the offset never wraps for j < push_n.
  always_comb begin
    logic [1:0] off;
    ib_bus = '0;
    off    = '0;
    for (int j = 0; j < 4; j++) begin
      off = pc_q[3:2] + 2'(j);
      if (3'(j) < push_n)
        ib_bus[j*IB_DATA_BUS_WD +: IB_DATA_BUS_WD] =
          {1'b1, line_base[31:4], off, 2'b00, line_q[{off, 5'b0} +: 32]};
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      // NOTE: the line buffer is a plain register, not a memory, so it is
      // reset along with the rest of the state.
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      line_q  <= line_d;
    end
  end

  assign bus.icache_req_valid = (state_q == REQ);
  assign bus.icache_req_addr  = line_base;
  assign bus.push_num         = push_n;
  assign bus.if1_to_ib        = ib_bus;

`ifndef SYNTHESIS
  a_bf_sz_legal: assert property (@(posedge clk) disable iff (rst)
    bus.if_bf_sz <= IB_DEPTH);
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    bus.icache_rsp_valid |-> (state_q == WAIT || state_q == DROP));
`endif

endmodule

// File: tb/tb_if1_fetch_ctrl.sv
// Directed bench for if1_fetch_ctrl: inputs change just after the falling edge,
// outputs are compared 1 ns later, well clear of the rising edge.
module tb_if1_fetch_ctrl;
  localparam int          W        = 65;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [127:0] stale_line = {32'hdead_beef, 32'hcafe_f00d, 32'h0bad_c0de, 32'hfeed_face};

  if1_fetch_ctrl_if #(.IB_WIDTH_LOG2(4), .IB_DATA_BUS_WD(W)) bus();

  if1_fetch_ctrl #(
    .IB_WIDTH(16), .IB_WIDTH_LOG2(4), .IB_DATA_BUS_WD(W), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .redirect_pc(redirect_pc), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h0f0f_a5a5;
  endfunction

  function automatic logic [127:0] mk_line(input logic [31:0] b);
    return {word_of(b + 32'd12), word_of(b + 32'd8), word_of(b + 32'd4), word_of(b)};
  endfunction

  function automatic logic [4*W-1:0] exp_bus(input logic [31:0] pc, input int n);
    logic [4*W-1:0] r;
    logic [31:0]    a;
    r = '0;
    for (int j = 0; j < n; j++) begin
      a = {pc[31:2], 2'b00} + 32'(4 * j);
      r[j*W +: W] = {1'b1, a, word_of(a)};
    end
    return r;
  endfunction

  // From a REQ cycle: handshake, one-cycle response, then leave the DUT in PUSH.
  task automatic run_fetch(input logic [127:0] line);
    @(negedge clk); bus.icache_req_ready = 1'b1;
    @(negedge clk); bus.icache_req_ready = 1'b0; bus.icache_rsp_valid = 1'b1; bus.icache_rsp_data = line;
    @(negedge clk); bus.icache_rsp_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", bus.icache_req_valid); end
    n_cmp++; if (bus.push_num !== 3'd0) begin n_bad++; $display("FAIL reset_push_num: got %0d want 0", bus.push_num); end
    n_cmp++; if (bus.if1_to_ib !== '0) begin n_bad++; $display("FAIL reset_if1_to_ib: got %h want 0", bus.if1_to_ib); end
    n_cmp++; if (bus.icache_req_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_addr: got %h want %h", bus.icache_req_addr, RESET_PC); end
  endtask

  task automatic test_basic;
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle_valid: got %b want 0", bus.icache_req_valid); end
    @(negedge clk); bus.icache_req_ready = 1'b1; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1) begin n_bad++; $display("FAIL basic_req_valid: got %b want 1", bus.icache_req_valid); end
    n_cmp++; if (bus.icache_req_addr !== 32'h1c00_0000) begin n_bad++; $display("FAIL basic_req_addr: got %h want 1c000000", bus.icache_req_addr); end
    @(negedge clk); bus.icache_req_ready = 1'b0; bus.icache_rsp_valid = 1'b1; bus.icache_rsp_data = mk_line(32'h1c00_0000); #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b0 || bus.push_num !== 3'd0) begin n_bad++; $display("FAIL basic_wait: got valid=%b push=%0d want 0/0", bus.icache_req_valid, bus.push_num); end
    @(negedge clk); bus.icache_rsp_valid = 1'b0; #1;
    n_cmp++; if (bus.push_num !== 3'd4) begin n_bad++; $display("FAIL basic_push_num: got %0d want 4", bus.push_num); end
    n_cmp++; if (bus.if1_to_ib !== exp_bus(32'h1c00_0000, 4)) begin n_bad++; $display("FAIL basic_entries: got %h want %h", bus.if1_to_ib, exp_bus(32'h1c00_0000, 4)); end
    @(negedge clk); #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1c00_0010) begin n_bad++; $display("FAIL basic_next_req: got %b/%h want 1/1c000010", bus.icache_req_valid, bus.icache_req_addr); end
  endtask

  task automatic test_flush_push;
    run_fetch(mk_line(32'h1c00_0010));
    flush = 1'b1; redirect_pc = 32'h1c00_002b; #1;
    n_cmp++; if (bus.push_num !== 3'd0 || bus.if1_to_ib !== '0) begin n_bad++; $display("FAIL flush_push_cycle: got push=%0d bus=%h want 0", bus.push_num, bus.if1_to_ib); end
    @(negedge clk); flush = 1'b0; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1c00_0020) begin n_bad++; $display("FAIL flush_push_req: got %b/%h want 1/1c000020", bus.icache_req_valid, bus.icache_req_addr); end
    run_fetch(mk_line(32'h1c00_0020)); #1;
    n_cmp++; if (bus.push_num !== 3'd2) begin n_bad++; $display("FAIL flush_push_num: got %0d want 2", bus.push_num); end
    n_cmp++; if (bus.if1_to_ib !== exp_bus(32'h1c00_0028, 2)) begin n_bad++; $display("FAIL flush_push_entries: got %h want %h", bus.if1_to_ib, exp_bus(32'h1c00_0028, 2)); end
    @(negedge clk); #1;
    n_cmp++; if (bus.icache_req_addr !== 32'h1c00_0030) begin n_bad++; $display("FAIL flush_push_next: got %h want 1c000030", bus.icache_req_addr); end
  endtask

  task automatic test_ib_full;
    run_fetch(mk_line(32'h1c00_0030));
    bus.if_bf_sz = 5'd13; #1;
    n_cmp++; if (bus.push_num !== 3'd0 || bus.if1_to_ib !== '0) begin n_bad++; $display("FAIL full_13_a: got push=%0d bus=%h want 0", bus.push_num, bus.if1_to_ib); end
    @(negedge clk); #1;
    n_cmp++; if (bus.push_num !== 3'd0 || bus.icache_req_valid !== 1'b0) begin n_bad++; $display("FAIL full_13_hold: got push=%0d valid=%b want 0/0", bus.push_num, bus.icache_req_valid); end
    @(negedge clk); bus.if_bf_sz = 5'd12; #1;
    n_cmp++; if (bus.push_num !== 3'd4) begin n_bad++; $display("FAIL full_12_num: got %0d want 4", bus.push_num); end
    n_cmp++; if (bus.if1_to_ib !== exp_bus(32'h1c00_0030, 4)) begin n_bad++; $display("FAIL full_12_entries: got %h want %h", bus.if1_to_ib, exp_bus(32'h1c00_0030, 4)); end
    @(negedge clk); bus.if_bf_sz = 5'd0; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1c00_0040) begin n_bad++; $display("FAIL full_next_req: got %b/%h want 1/1c000040", bus.icache_req_valid, bus.icache_req_addr); end
  endtask

  task automatic test_flush_wait;
    @(negedge clk); bus.icache_req_ready = 1'b1;
    @(negedge clk); bus.icache_req_ready = 1'b0; flush = 1'b1; redirect_pc = 32'h1c00_0100; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b0) begin n_bad++; $display("FAIL fwait_in_wait: got valid=%b want 0", bus.icache_req_valid); end
    @(negedge clk); flush = 1'b0; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b0) begin n_bad++; $display("FAIL fwait_drop: got valid=%b want 0", bus.icache_req_valid); end
    @(negedge clk);
    @(negedge clk); bus.icache_rsp_valid = 1'b1; bus.icache_rsp_data = stale_line; #1;
    n_cmp++; if (bus.push_num !== 3'd0 || bus.icache_req_valid !== 1'b0) begin n_bad++; $display("FAIL fwait_stale_rsp: got push=%0d valid=%b want 0/0", bus.push_num, bus.icache_req_valid); end
    @(negedge clk); bus.icache_rsp_valid = 1'b0; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1c00_0100 || bus.push_num !== 3'd0) begin n_bad++; $display("FAIL fwait_new_req: got %b/%h push=%0d want 1/1c000100/0", bus.icache_req_valid, bus.icache_req_addr, bus.push_num); end
    run_fetch(mk_line(32'h1c00_0100)); #1;
    n_cmp++; if (bus.push_num !== 3'd4 || bus.if1_to_ib !== exp_bus(32'h1c00_0100, 4)) begin n_bad++; $display("FAIL fwait_push: got %0d %h want 4 %h", bus.push_num, bus.if1_to_ib, exp_bus(32'h1c00_0100, 4)); end
  endtask

  task automatic test_flush_coincide;
    @(negedge clk); bus.icache_req_ready = 1'b1;
    @(negedge clk); bus.icache_req_ready = 1'b0; flush = 1'b1; redirect_pc = 32'h1c00_0200;
    bus.icache_rsp_valid = 1'b1; bus.icache_rsp_data = stale_line; #1;
    n_cmp++; if (bus.push_num !== 3'd0) begin n_bad++; $display("FAIL coin_rsp_push: got %0d want 0", bus.push_num); end
    @(negedge clk); flush = 1'b0; bus.icache_rsp_valid = 1'b0; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1c00_0200 || bus.push_num !== 3'd0) begin n_bad++; $display("FAIL coin_rsp_req: got %b/%h push=%0d want 1/1c000200/0", bus.icache_req_valid, bus.icache_req_addr, bus.push_num); end
    bus.icache_req_ready = 1'b1; flush = 1'b1; redirect_pc = 32'h1c00_0300; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1c00_0200) begin n_bad++; $display("FAIL coin_hs_req: got %b/%h want 1/1c000200", bus.icache_req_valid, bus.icache_req_addr); end
    @(negedge clk); bus.icache_req_ready = 1'b0; flush = 1'b0; bus.icache_rsp_valid = 1'b1; bus.icache_rsp_data = stale_line; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b0 || bus.push_num !== 3'd0) begin n_bad++; $display("FAIL coin_hs_drop: got valid=%b push=%0d want 0/0", bus.icache_req_valid, bus.push_num); end
    @(negedge clk); bus.icache_rsp_valid = 1'b0; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1c00_0300 || bus.push_num !== 3'd0) begin n_bad++; $display("FAIL coin_hs_req2: got %b/%h push=%0d want 1/1c000300/0", bus.icache_req_valid, bus.icache_req_addr, bus.push_num); end
    run_fetch(mk_line(32'h1c00_0300)); #1;
    n_cmp++; if (bus.push_num !== 3'd4 || bus.if1_to_ib !== exp_bus(32'h1c00_0300, 4)) begin n_bad++; $display("FAIL coin_push: got %0d %h want 4 %h", bus.push_num, bus.if1_to_ib, exp_bus(32'h1c00_0300, 4)); end
    @(negedge clk); flush = 1'b1; redirect_pc = 32'h1c00_0404; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1c00_0310) begin n_bad++; $display("FAIL coin_nohs_req: got %b/%h want 1/1c000310", bus.icache_req_valid, bus.icache_req_addr); end
    @(negedge clk); flush = 1'b0; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1c00_0400) begin n_bad++; $display("FAIL coin_nohs_new: got %b/%h want 1/1c000400", bus.icache_req_valid, bus.icache_req_addr); end
    run_fetch(mk_line(32'h1c00_0400)); #1;
    n_cmp++; if (bus.push_num !== 3'd3 || bus.if1_to_ib !== exp_bus(32'h1c00_0404, 3)) begin n_bad++; $display("FAIL coin_push3: got %0d %h want 3 %h", bus.push_num, bus.if1_to_ib, exp_bus(32'h1c00_0404, 3)); end
  endtask

  task automatic test_pc_wrap;
    @(negedge clk); flush = 1'b1; redirect_pc = 32'hffff_fff0;
    @(negedge clk); flush = 1'b0; #1;
    n_cmp++; if (bus.icache_req_addr !== 32'hffff_fff0) begin n_bad++; $display("FAIL wrap_req: got %h want fffffff0", bus.icache_req_addr); end
    run_fetch(mk_line(32'hffff_fff0)); #1;
    n_cmp++; if (bus.push_num !== 3'd4 || bus.if1_to_ib !== exp_bus(32'hffff_fff0, 4)) begin n_bad++; $display("FAIL wrap_push: got %0d %h want 4 %h", bus.push_num, bus.if1_to_ib, exp_bus(32'hffff_fff0, 4)); end
    @(negedge clk); #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_next: got %b/%h want 1/00000000", bus.icache_req_valid, bus.icache_req_addr); end
  endtask

  task automatic test_ib_boundary;
    @(negedge clk); flush = 1'b1; redirect_pc = 32'h0000_000e;
    @(negedge clk); flush = 1'b0; #1;
    n_cmp++; if (bus.icache_req_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL bound_req: got %h want 00000000", bus.icache_req_addr); end
    run_fetch(mk_line(32'h0000_0000));
    bus.if_bf_sz = 5'd16; #1;
    n_cmp++; if (bus.push_num !== 3'd0) begin n_bad++; $display("FAIL bound_16: got %0d want 0", bus.push_num); end
    @(negedge clk); bus.if_bf_sz = 5'd15; #1;
    n_cmp++; if (bus.push_num !== 3'd1 || bus.if1_to_ib !== exp_bus(32'h0000_000c, 1)) begin n_bad++; $display("FAIL bound_15: got %0d %h want 1 %h", bus.push_num, bus.if1_to_ib, exp_bus(32'h0000_000c, 1)); end
    @(negedge clk); bus.if_bf_sz = 5'd0; #1;
    n_cmp++; if (bus.icache_req_addr !== 32'h0000_0010) begin n_bad++; $display("FAIL bound_next: got %h want 00000010", bus.icache_req_addr); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); bus.icache_req_ready = 1'b1;
    @(negedge clk); bus.icache_req_ready = 1'b0; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_wait: got %b want 0", bus.icache_req_valid); end
    #2 rst = 1'b1; #1;
    n_cmp++; if (bus.icache_req_addr !== RESET_PC || bus.push_num !== 3'd0 || bus.if1_to_ib !== '0) begin n_bad++; $display("FAIL rstmid_async: got %h push=%0d want %h push=0", bus.icache_req_addr, bus.push_num, RESET_PC); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got %b want 0", bus.icache_req_valid); end
    @(negedge clk); #1;
    n_cmp++; if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== RESET_PC) begin n_bad++; $display("FAIL rstmid_restart: got %b/%h want 1/%h", bus.icache_req_valid, bus.icache_req_addr, RESET_PC); end
    run_fetch(mk_line(RESET_PC)); #1;
    n_cmp++; if (bus.push_num !== 3'd4 || bus.if1_to_ib !== exp_bus(RESET_PC, 4)) begin n_bad++; $display("FAIL rstmid_push: got %0d %h want 4 %h", bus.push_num, bus.if1_to_ib, exp_bus(RESET_PC, 4)); end
  endtask

  initial begin
    bus.icache_req_ready = 1'b0;
    bus.icache_rsp_valid = 1'b0;
    bus.icache_rsp_data  = '0;
    bus.if_bf_sz         = '0;
    test_reset();
    test_basic();
    test_flush_push();
    test_ib_full();
    test_flush_wait();
    test_flush_coincide();
    test_pc_wrap();
    test_ib_boundary();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
